// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs feeding one registered common data bus.
// Valid/ready: a unit's result is taken on a cycle where src_valid[i] and src_ready[i]
// are both high; src_ready depends only on registered occupancy, never on src_valid.
module wb_arbiter #(
    parameter int PHYS_REG_BITS = 6,
    parameter int ARCH_REG_BITS = 5,
    parameter int ROB_IDX_BITS  = 5,
    parameter int NUM_SRC       = 5,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [NUM_SRC-1:0]                  src_valid,
    output logic [NUM_SRC-1:0]                  src_ready,
    input  logic [NUM_SRC*PHYS_REG_BITS-1:0]    src_pd,
    input  logic [NUM_SRC*ARCH_REG_BITS-1:0]    src_ad,
    input  logic [NUM_SRC*32-1:0]               src_v,
    input  logic [NUM_SRC*ROB_IDX_BITS-1:0]     src_rob,
    output logic                                cdb_valid,
    output logic [$clog2(NUM_SRC)-1:0]          cdb_src,
    output logic [PHYS_REG_BITS-1:0]            cdb_pd,
    output logic [ARCH_REG_BITS-1:0]            cdb_ad,
    output logic [31:0]                         cdb_v,
    output logic [ROB_IDX_BITS-1:0]             cdb_rob,
    output logic                                regf_we
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int SRC_W   = $clog2(NUM_SRC);
    localparam int ENTRY_W = PHYS_REG_BITS + ARCH_REG_BITS + 32 + ROB_IDX_BITS;

    logic [CNT_W-1:0]   count_q  [NUM_SRC];
    logic [CNT_W-1:0]   count_d  [NUM_SRC];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_SRC];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_SRC];
    logic [ENTRY_W-1:0] mem_q    [NUM_SRC][FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d    [NUM_SRC][FIFO_DEPTH];
    logic [SRC_W-1:0]   rr_q, rr_d;

    logic                     cdb_valid_q, cdb_valid_d;
    logic [SRC_W-1:0]         cdb_src_q, cdb_src_d;
    logic [PHYS_REG_BITS-1:0] cdb_pd_q, cdb_pd_d;
    logic [ARCH_REG_BITS-1:0] cdb_ad_q, cdb_ad_d;
    logic [31:0]              cdb_v_q, cdb_v_d;
    logic [ROB_IDX_BITS-1:0]  cdb_rob_q, cdb_rob_d;
    logic                     regf_we_q, regf_we_d;

    logic [NUM_SRC-1:0] push, nonempty;
    logic               found;
    logic [SRC_W-1:0]   win, cand;
    logic [ENTRY_W-1:0] head;

    // Occupancy-derived ready/non-empty flags and accepted pushes
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (count_q[i] != CNT_W'(FIFO_DEPTH));
            nonempty[i]  = (count_q[i] != '0);
            push[i]      = src_valid[i] && src_ready[i];
        end
    end

    // Round-robin search from rr_q; first non-empty FIFO wins, flush suppresses the pop
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = SRC_W'((int'(rr_q) + k) % NUM_SRC);
            if (!found && nonempty[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        head = mem_q[win][rd_ptr_q[win]];
        rr_d = rr_q;
        if (found && !flush)
            rr_d = (win == SRC_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
    end

    // FIFO bookkeeping: push, pop of the winner, and flush clearing
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            count_d[i]  = count_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (flush) begin
                count_d[i]  = '0;
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
            end else begin
                if (push[i]) begin
                    mem_d[i][wr_ptr_q[i]] = {src_pd[i*PHYS_REG_BITS +: PHYS_REG_BITS],
                                             src_ad[i*ARCH_REG_BITS +: ARCH_REG_BITS],
                                             src_v[i*32 +: 32],
                                             src_rob[i*ROB_IDX_BITS +: ROB_IDX_BITS]};
                    wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
                end
                if (found && (win == SRC_W'(i)))
                    rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
                count_d[i] = count_q[i] + CNT_W'(push[i])
                           - CNT_W'(found && (win == SRC_W'(i)));
            end
        end
    end

    // Next CDB contents: popped head, value zeroed for arch reg 0, no write for phys reg 0
    always_comb begin
        cdb_valid_d = found && !flush;
        cdb_src_d   = cdb_src_q;
        cdb_pd_d    = cdb_pd_q;
        cdb_ad_d    = cdb_ad_q;
        cdb_v_d     = cdb_v_q;
        cdb_rob_d   = cdb_rob_q;
        regf_we_d   = 1'b0;
        if (cdb_valid_d) begin
            cdb_src_d = win;
            cdb_pd_d  = head[ENTRY_W-1 -: PHYS_REG_BITS];
            cdb_ad_d  = head[ENTRY_W-PHYS_REG_BITS-1 -: ARCH_REG_BITS];
            cdb_v_d   = (cdb_ad_d == '0) ? 32'd0 : head[ROB_IDX_BITS +: 32];
            cdb_rob_d = head[ROB_IDX_BITS-1:0];
            regf_we_d = (cdb_pd_d != '0);
        end
    end

    // Control and CDB registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            rr_q        <= '0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            cdb_pd_q    <= '0;
            cdb_ad_q    <= '0;
            cdb_v_q     <= '0;
            cdb_rob_q   <= '0;
            regf_we_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cdb_pd_q    <= cdb_pd_d;
            cdb_ad_q    <= cdb_ad_d;
            cdb_v_q     <= cdb_v_d;
            cdb_rob_q   <= cdb_rob_d;
            regf_we_q   <= regf_we_d;
        end
    end

    // FIFO storage carries no reset; occupancy alone decides what is live
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_src   = cdb_src_q;
    assign cdb_pd    = cdb_pd_q;
    assign cdb_ad    = cdb_ad_q;
    assign cdb_v     = cdb_v_q;
    assign cdb_rob   = cdb_rob_q;
    assign regf_we   = regf_we_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single result, zero rules, round-robin,
// backpressure, flush and reset-with-flush.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [4:0]  src_valid;
    logic [4:0]  src_ready;
    logic [29:0] src_pd;
    logic [24:0] src_ad;
    logic [159:0] src_v;
    logic [24:0] src_rob;
    logic        cdb_valid;
    logic [2:0]  cdb_src;
    logic [5:0]  cdb_pd;
    logic [4:0]  cdb_ad;
    logic [31:0] cdb_v;
    logic [4:0]  cdb_rob;
    logic        regf_we;

    int checks = 0;
    int errors = 0;
    logic [31:0] log0_q[$];
    logic [31:0] log1_q[$];
    logic [31:0] exp_q[$];
    logic [3:0]  exp_r1;
    logic [3:0]  exp_r0;
    int an, bn, other;
    logic r0, r1;

    wb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_pd(src_pd), .src_ad(src_ad), .src_v(src_v), .src_rob(src_rob),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_pd(cdb_pd), .cdb_ad(cdb_ad),
        .cdb_v(cdb_v), .cdb_rob(cdb_rob), .regf_we(regf_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [5:0] pd, input logic [4:0] ad,
                           input logic [31:0] v, input logic [4:0] rob);
        src_pd[i*6 +: 6]   = pd;
        src_ad[i*5 +: 5]   = ad;
        src_v[i*32 +: 32]  = v;
        src_rob[i*5 +: 5]  = rob;
    endtask

    task automatic record();
        if (cdb_valid === 1'b1) begin
            if (cdb_src === 3'd0) log0_q.push_back(cdb_v);
            else if (cdb_src === 3'd1) log1_q.push_back(cdb_v);
            else other++;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; src_valid = '0;
        src_pd = '0; src_ad = '0; src_v = '0; src_rob = '0;
        other = 0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_valid", 32'(cdb_valid), 32'd0);
        chk("rst_we",    32'(regf_we),   32'd0);
        chk("rst_ready", 32'(src_ready), 32'h1f);
        chk("rst_src",   32'(cdb_src),   32'd0);
        chk("rst_pd",    32'(cdb_pd),    32'd0);
        chk("rst_ad",    32'(cdb_ad),    32'd0);
        chk("rst_v",     cdb_v,          32'd0);
        chk("rst_rob",   32'(cdb_rob),   32'd0);

        // single result from src 0, rr 0 -> 1
        set_src(0, 6'd12, 5'd3, 32'hDEADBEEF, 5'd7);
        src_valid = 5'b00001;
        tick(); src_valid = '0;
        chk("single_t1_valid", 32'(cdb_valid), 32'd0);
        tick();
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_src",   32'(cdb_src),   32'd0);
        chk("single_we",    32'(regf_we),   32'd1);
        chk("single_pd",    32'(cdb_pd),    32'd12);
        chk("single_ad",    32'(cdb_ad),    32'd3);
        chk("single_v",     cdb_v,          32'hDEADBEEF);
        chk("single_rob",   32'(cdb_rob),   32'd7);
        tick();
        chk("single_t3_valid", 32'(cdb_valid), 32'd0);

        // arch reg 0 forces value 0, rr 1 -> 2
        set_src(1, 6'd9, 5'd0, 32'h1234, 5'd2);
        src_valid = 5'b00010;
        tick(); src_valid = '0; tick();
        chk("ad0_valid", 32'(cdb_valid), 32'd1);
        chk("ad0_src",   32'(cdb_src),   32'd1);
        chk("ad0_v",     cdb_v,          32'd0);
        chk("ad0_we",    32'(regf_we),   32'd1);

        // phys reg 0 completes without writing, rr stays 2
        set_src(1, 6'd0, 5'd4, 32'h5555, 5'd3);
        src_valid = 5'b00010;
        tick(); src_valid = '0; tick();
        chk("pd0_valid", 32'(cdb_valid), 32'd1);
        chk("pd0_we",    32'(regf_we),   32'd0);
        chk("pd0_v",     cdb_v,          32'h5555);
        tick();

        // bring rr to 0 via a lone src 4 win
        set_src(4, 6'd20, 5'd20, 32'h4444, 5'd20);
        src_valid = 5'b10000;
        tick(); src_valid = '0; tick();
        chk("prep4_src", 32'(cdb_src), 32'd4);
        tick();

        // all five push together from rr 0 -> order 0..4
        for (int i = 0; i < 5; i++)
            set_src(i, 6'(30 + i), 5'(10 + i), 32'hA000 + 32'(i), 5'(20 + i));
        src_valid = 5'b11111;
        tick(); src_valid = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_valid", 32'(cdb_valid), 32'd1);
            chk("rr_src",   32'(cdb_src),   32'(k));
            chk("rr_v",     cdb_v,          32'hA000 + 32'(k));
        end
        tick();
        chk("rr_end_valid", 32'(cdb_valid), 32'd0);

        // lone src 2 moves rr to 3
        set_src(2, 6'd5, 5'd5, 32'hB000, 5'd5);
        src_valid = 5'b00100;
        tick(); src_valid = '0; tick();
        chk("prep2_src", 32'(cdb_src), 32'd2);
        tick();

        // src 2 and 4 from rr 3 -> 4 then 2
        set_src(2, 6'd6, 5'd6, 32'hB002, 5'd6);
        set_src(4, 6'd7, 5'd7, 32'hB004, 5'd7);
        src_valid = 5'b10100;
        tick(); src_valid = '0; tick();
        chk("rr24_first_src", 32'(cdb_src), 32'd4);
        chk("rr24_first_v",   cdb_v,        32'hB004);
        tick();
        chk("rr24_second_src", 32'(cdb_src), 32'd2);
        chk("rr24_second_v",   cdb_v,        32'hB002);
        tick();
        chk("rr24_end_valid", 32'(cdb_valid), 32'd0);

        // backpressure: src 1 valid 4 cycles, src 0 fed alongside
        exp_r1 = 4'b1011;
        exp_r0 = 4'b0111;
        an = 0; bn = 0;
        for (int c = 0; c < 4; c++) begin
            set_src(0, 6'd1, 5'd1, 32'hC000 + 32'(an), 5'd1);
            set_src(1, 6'd2, 5'd2, 32'hD000 + 32'(bn), 5'd2);
            src_valid = 5'b00011;
            r0 = src_ready[0];
            r1 = src_ready[1];
            chk("bp_ready1", 32'(r1), 32'(exp_r1[c]));
            chk("bp_ready0", 32'(r0), 32'(exp_r0[c]));
            tick();
            record();
            if (r0) an++;
            if (r1) bn++;
        end
        src_valid = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            record();
        end
        chk("bp_src1_accepted", 32'(bn), 32'd3);
        chk("bp_src0_accepted", 32'(an), 32'd3);
        chk("bp_other", 32'(other), 32'd0);
        exp_q = '{32'hD000, 32'hD001, 32'hD002};
        chk("bp_src1_count", 32'(log1_q.size()), 32'd3);
        foreach (exp_q[j])
            if (j < log1_q.size()) chk("bp_src1_order", log1_q[j], exp_q[j]);
        exp_q = '{32'hC000, 32'hC001, 32'hC002};
        chk("bp_src0_count", 32'(log0_q.size()), 32'd3);
        foreach (exp_q[j])
            if (j < log0_q.size()) chk("bp_src0_order", log0_q[j], exp_q[j]);

        // flush with buffered entries in srcs 0..2 and a push in the flush cycle
        for (int i = 0; i < 3; i++) set_src(i, 6'd8, 5'd8, 32'hE000 + 32'(i), 5'd8);
        src_valid = 5'b00111;
        tick();
        for (int i = 0; i < 3; i++) set_src(i, 6'd8, 5'd8, 32'hE010 + 32'(i), 5'd8);
        tick();
        set_src(3, 6'd9, 5'd9, 32'hF333, 5'd9);
        src_valid = 5'b01000;
        flush = 1'b1;
        tick();
        flush = 1'b0; src_valid = '0;
        chk("flush_t1_valid", 32'(cdb_valid), 32'd0);
        chk("flush_t1_ready", 32'(src_ready), 32'h1f);
        tick();
        chk("flush_t2_valid", 32'(cdb_valid), 32'd0);
        tick();
        chk("flush_t3_valid", 32'(cdb_valid), 32'd0);
        set_src(3, 6'd10, 5'd10, 32'hF444, 5'd10);
        src_valid = 5'b01000;
        tick(); src_valid = '0; tick();
        chk("flush_new_valid", 32'(cdb_valid), 32'd1);
        chk("flush_new_src",   32'(cdb_src),   32'd3);
        chk("flush_new_v",     cdb_v,          32'hF444);
        tick();
        chk("flush_dropped", 32'(cdb_valid), 32'd0);

        // rst together with flush mid-operation
        for (int i = 0; i < 5; i++) set_src(i, 6'd11, 5'd11, 32'h7000 + 32'(i), 5'd11);
        src_valid = 5'b11111;
        tick(); src_valid = '0; tick();
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        chk("rstfl_valid", 32'(cdb_valid), 32'd0);
        chk("rstfl_we",    32'(regf_we),   32'd0);
        chk("rstfl_v",     cdb_v,          32'd0);
        chk("rstfl_src",   32'(cdb_src),   32'd0);
        chk("rstfl_ready", 32'(src_ready), 32'h1f);
        tick();
        chk("rstfl_lost", 32'(cdb_valid), 32'd0);

        // rr back at 0 after reset: src 0 beats src 4
        set_src(0, 6'd3, 5'd3, 32'h9000, 5'd3);
        set_src(4, 6'd4, 5'd4, 32'h9004, 5'd4);
        src_valid = 5'b10001;
        tick(); src_valid = '0; tick();
        chk("rr_reset_first",  32'(cdb_src), 32'd0);
        tick();
        chk("rr_reset_second", 32'(cdb_src), 32'd4);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
